// File: rtl/mult_div.sv
// Iterative 32-cycle multiply/divide unit with HI/LO result registers.
// One shift-add or restoring-divide step per cycle, then a sign fixup.
module mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  localparam int CW = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 quo_neg_q, quo_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       rem_sh, trial, sum;
  logic [2*WIDTH-1:0]   acc_neg;

  // The low half holds the multiplier or the dividend, so both ops load alike.
  assign a_neg   = ~op[0] & A[WIDTH-1];
  assign b_neg   = ~op[0] & B[WIDTH-1];
  assign mag_a   = a_neg ? ({WIDTH{1'b0}} - A) : A;
  assign mag_b   = b_neg ? ({WIDTH{1'b0}} - B) : B;
  assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign trial   = rem_sh - {1'b0, opb_q};
  assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign acc_neg = {(2*WIDTH){1'b0}} - acc_q;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = A;
        if (lo_we) lo_d = A;
        if (start) begin
          is_div_d  = op[1];
          // A zero divisor leaves the all-ones quotient unsigned-looking.
          quo_neg_d = (a_neg ^ b_neg) & ~(op[1] & (B == {WIDTH{1'b0}}));
          rem_neg_d = a_neg;
          acc_d     = {{WIDTH{1'b0}}, mag_a};
          opb_d     = mag_b;
          cnt_d     = '0;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        if (is_div_q) begin
          if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (is_div_q) begin
          lo_d = quo_neg_q ? acc_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = rem_neg_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = quo_neg_q ? acc_neg : acc_q;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: datapath registers are reset too, keeping HI/LO and the pipeline deterministic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      acc_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; only 32 is required to be supported.
REQ-002 Port clk SHALL be an input of 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port reset SHALL be an input of 1 bit: asynchronous, active-low reset.
REQ-004 Port start SHALL be an input of 1 bit: request to begin an operation, sampled on the rising edge.
REQ-005 Port op SHALL be an input of 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Port A SHALL be an input of 32 bits: multiplicand or dividend.
REQ-007 Port B SHALL be an input of 32 bits: multiplier or divisor.
REQ-008 Port hi_we and port lo_we SHALL each be an input of 1 bit: direct write of HI or LO from A (mthi/mtlo).
REQ-009 Port HI SHALL be an output of 32 bits: high product or remainder, registered.
REQ-010 Port LO SHALL be an output of 32 bits: low product or quotient, registered.
REQ-011 Port busy SHALL be an output of 1 bit: an operation is in progress.
REQ-012 Port done SHALL be an output of 1 bit: a one-cycle pulse marking that HI/LO hold a new result.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and FIX, with a 5-bit iteration counter.
REQ-014 In IDLE with start=1, the block SHALL latch op, take the magnitudes of A and B (signed ops only), record the result signs, clear the counter and go to CALC.
REQ-015 In CALC, the block SHALL perform one iteration per cycle and go to FIX after the iteration in which the counter equals 31 (32 iterations).
REQ-016 A multiply iteration SHALL be a shift-add on a 64-bit {acc, multiplier} register.
REQ-017 A divide iteration SHALL be restoring division: shift the remainder left, subtract the divisor, keep the result if it is non-negative and set the quotient bit.
REQ-018 In FIX, the block SHALL apply the sign fixup and return to IDLE.
REQ-019 The sign fixup SHALL be:
 - MULT: negate the 64-bit product if sign(A)^sign(B).
 - DIV: negate the quotient if sign(A)^sign(B); the remainder takes the sign of A.
REQ-020 On the FIX->IDLE edge, the block SHALL write HI/LO and set done=1 for exactly one cycle.
REQ-021 The latency SHALL be: start sampled at edge E0, done high in the cycle following edge E33 (33 cycles).
REQ-022 busy SHALL be 1 exactly while the state is CALC or FIX; busy SHALL be 0 in the done cycle.
REQ-023 start SHALL be ignored while busy=1, and the in-flight operation SHALL be unaffected.
REQ-024 A start in the done cycle (IDLE) SHALL be accepted, so back-to-back operations are allowed.
REQ-025 HI and LO SHALL keep their values during CALC and FIX; they change only on result write or direct write.
REQ-026 Direct writes:
 - In IDLE, hi_we=1 SHALL load HI<=A and lo_we=1 SHALL load LO<=A on the same edge.
 - While busy, hi_we and lo_we SHALL be ignored.
 - If start=1 together with hi_we/lo_we in IDLE, the write SHALL take effect and the operation SHALL start.
REQ-027 Divide by zero (B=0, DIV or DIVU) SHALL give HI=A (the original operand) and LO=0xFFFFFFFF, with the same 33-cycle latency and no exception.
REQ-028 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0 (wrap, no trap).
REQ-029 A magnitude of 0x80000000 SHALL be handled as the unsigned value 2^31, not overflowed.

Reset
REQ-030 When reset=0, the block SHALL immediately force state=IDLE, counter=0, HI=0, LO=0, busy=0, done=0, independent of clk.
REQ-031 A reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow and HI/LO SHALL be 0.
REQ-032 After reset is released, the first start SHALL be accepted on the next rising edge.

Verification
REQ-033 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, with a single done pulse.
REQ-034 MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
REQ-035 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); then DIVU A=100, B=0 -> HI=100, LO=0xFFFFFFFF.
REQ-036 Start DIVU 100/7, pulse start again at cycle 5 with different operands, and pulse hi_we at cycle 10 -> both ignored; result LO=14, HI=2; busy=1 for cycles 1..33.
REQ-037 Start MULTU 3*5, assert reset at cycle 20 -> busy=0, HI=LO=0 immediately; no done; a new MULTU 3*5 after release -> LO=15.
REQ-038 In IDLE, hi_we with A=0x12345678, then lo_we with A=0x9ABCDEF0 -> HI/LO hold these values and done stays 0.
